// File: rtl/pio_cmd_sequencer.sv
// HPS command sequencer: decodes toggle-handshaked commands from the HPS PIO,
// accesses switches/keys/LEDs/blink timer, and posts one response per command.
module pio_cmd_sequencer #(
  parameter int unsigned BLINK_DEFAULT   = 25000000,
  parameter int unsigned KEY_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pp_out,
  output logic [31:0] pp_in,
  input  logic [9:0]  sw,
  input  logic [3:0]  key,
  output logic [9:0]  led
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam logic [3:0] OpNop      = 4'd0;
  localparam logic [3:0] OpInc      = 4'd1;
  localparam logic [3:0] OpReadIo   = 4'd2;
  localparam logic [3:0] OpSetLed   = 4'd3;
  localparam logic [3:0] OpSetBlink = 4'd4;
  localparam logic [3:0] OpGetCnt   = 4'd5;
  localparam logic [3:0] OpWait     = 4'd6;

  logic [1:0]  state_q, state_d;
  logic        tgl_q, tgl_d;
  logic [3:0]  op_q, op_d;
  logic [25:0] arg_q, arg_d;
  logic        err_q, err_d;
  logic [25:0] result_q, result_d;
  logic [15:0] wait_q, wait_d;
  logic [31:0] pp_in_q, pp_in_d;
  logic [9:0]  led_q, led_d;
  logic [25:0] blink_period_q, blink_period_d;
  logic [25:0] blink_cnt_q, blink_cnt_d;
  logic [25:0] cmd_count_q, cmd_count_d;

  logic [KEY_SYNC_STAGES-1:0][9:0] sw_sync_q;
  logic [KEY_SYNC_STAGES-1:0][3:0] key_sync_q;
  logic [9:0] sw_sync;
  logic [3:0] key_sync;

  // No opcode consumes arg bit 26.
  logic unused_arg26;
  assign unused_arg26 = pp_out[26];

  assign sw_sync  = sw_sync_q[KEY_SYNC_STAGES-1];
  assign key_sync = key_sync_q[KEY_SYNC_STAGES-1];
  assign pp_in    = pp_in_q;
  assign led      = led_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_sync_q  <= '0;
      key_sync_q <= '1;
    end else begin
      sw_sync_q  <= {sw_sync_q[KEY_SYNC_STAGES-2:0], sw};
      key_sync_q <= {key_sync_q[KEY_SYNC_STAGES-2:0], key};
    end
  end

  always_comb begin
    state_d        = state_q;
    tgl_d          = tgl_q;
    op_d           = op_q;
    arg_d          = arg_q;
    err_d          = err_q;
    result_d       = result_q;
    wait_d         = wait_q;
    pp_in_d        = pp_in_q;
    led_d          = led_q;
    blink_period_d = blink_period_q;
    cmd_count_d    = cmd_count_q;

    // Free-running blink; a SET_BLINK below may override the counter but not the toggle.
    if (blink_cnt_q == blink_period_q - 26'd1) begin
      blink_cnt_d = '0;
      led_d[0]    = ~led_q[0];
    end else begin
      blink_cnt_d = blink_cnt_q + 26'd1;
    end

    case (state_q)
      StIdle: begin
        if (pp_out[31] != pp_in_q[31]) begin
          tgl_d   = pp_out[31];
          op_d    = pp_out[30:27];
          arg_d   = pp_out[25:0];
          state_d = StExec;
        end
      end
      StExec: begin
        err_d    = 1'b0;
        result_d = '0;
        state_d  = StResp;
        case (op_q)
          OpNop: ;
          OpInc:    result_d = arg_q + 26'd1;
          OpReadIo: result_d = {12'b0, ~key_sync, sw_sync};
          OpSetLed: begin
            led_d[9:1] = arg_q[8:0];
            result_d   = {17'b0, arg_q[8:0]};
          end
          OpSetBlink: begin
            if (arg_q >= 26'd2) begin
              blink_period_d = arg_q;
              blink_cnt_d    = '0;
              result_d       = arg_q;
            end else begin
              err_d = 1'b1;
            end
          end
          OpGetCnt: result_d = cmd_count_q;
          OpWait: begin
            result_d = {10'b0, arg_q[15:0]};
            wait_d   = arg_q[15:0];
            if (arg_q[15:0] != 16'd0) state_d = StWait;
          end
          default: err_d = 1'b1;
        endcase
      end
      StWait: begin
        if (wait_q == 16'd1) begin
          state_d = StResp;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end
      StResp: begin
        pp_in_d     = {tgl_q, err_q, op_q, result_q};
        cmd_count_d = cmd_count_q + 26'd1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      tgl_q          <= 1'b0;
      op_q           <= '0;
      arg_q          <= '0;
      err_q          <= 1'b0;
      result_q       <= '0;
      wait_q         <= '0;
      pp_in_q        <= '0;
      led_q          <= '0;
      blink_period_q <= 26'(BLINK_DEFAULT);
      blink_cnt_q    <= '0;
      cmd_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      tgl_q          <= tgl_d;
      op_q           <= op_d;
      arg_q          <= arg_d;
      err_q          <= err_d;
      result_q       <= result_d;
      wait_q         <= wait_d;
      pp_in_q        <= pp_in_d;
      led_q          <= led_d;
      blink_period_q <= blink_period_d;
      blink_cnt_q    <= blink_cnt_d;
      cmd_count_q    <= cmd_count_d;
    end
  end

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// Directed bench for pio_cmd_sequencer: handshake latency, every opcode class,
// blink period, request toggles while busy and reset during WAIT.
module tb_pio_cmd_sequencer;

  logic        clk;
  logic        reset_n;
  logic [31:0] pp_out;
  logic [31:0] pp_in;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [9:0]  led;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_resp;

  pio_cmd_sequencer #(
    .BLINK_DEFAULT  (16),
    .KEY_SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .pp_out (pp_out),
    .pp_in  (pp_in),
    .sw     (sw),
    .key    (key),
    .led    (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] cmd(input logic t, input logic [3:0] op, input logic [26:0] a);
    return {t, op, a};
  endfunction

  function automatic logic [31:0] resp(input logic t, input logic e, input logic [3:0] op,
                                       input logic [25:0] r);
    return {t, e, op, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Capture edge counts as edge 1; the response must appear on edge 3, not edge 2.
  task automatic run_cmd(input string tag, input logic [31:0] c, input logic [31:0] exp);
    pp_out = c;
    tick();
    tick();
    chk({tag, "_early"}, pp_in, last_resp);
    tick();
    chk(tag, pp_in, exp);
    last_resp = exp;
  endtask

  // Locate the next led[0] edge, then require a full period of 4 cycles.
  task automatic check_period4(input string tag);
    logic l;
    logic found;
    l = led[0];
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (led[0] != l) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_found"}, {31'b0, found}, 32'd1);
    l = led[0];
    tick(); tick(); tick();
    chk({tag, "_hold"}, {31'b0, led[0]}, {31'b0, l});
    tick();
    chk({tag, "_toggle"}, {31'b0, led[0]}, {31'b0, ~l});
  endtask

  initial begin
    logic l0;
    reset_n   = 1'b0;
    pp_out    = '0;
    sw        = '0;
    key       = 4'hF;
    last_resp = '0;
    #12;
    chk("reset_pp_in", pp_in, 32'h0);
    chk("reset_led", {22'b0, led}, 32'h0);

    // First toggle exactly 16 edges after release.
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) tick();
    chk("blink_default_pre", {31'b0, led[0]}, 32'd0);
    tick();
    chk("blink_default_hit", {31'b0, led[0]}, 32'd1);

    run_cmd("inc_wrap", cmd(1'b1, 4'd1, 27'h3FFFFFF), resp(1'b1, 1'b0, 4'd1, 26'd0));
    run_cmd("inc_5", cmd(1'b0, 4'd1, 27'd5), resp(1'b0, 1'b0, 4'd1, 26'd6));

    sw  = 10'h2A5;
    key = 4'b1110;
    tick(); tick(); tick();
    run_cmd("read_io", cmd(1'b1, 4'd2, 27'd0), resp(1'b1, 1'b0, 4'd2, 26'h6A5));

    run_cmd("set_led", cmd(1'b0, 4'd3, 27'h1A5), resp(1'b0, 1'b0, 4'd3, 26'h1A5));
    chk("led_pattern", {23'b0, led[9:1]}, 32'h1A5);

    run_cmd("set_blink4", cmd(1'b1, 4'd4, 27'd4), resp(1'b1, 1'b0, 4'd4, 26'd4));
    // Counter is 0 after EXEC, 1 after RESP, so the wrap is 3 edges out.
    l0 = led[0];
    tick(); tick();
    chk("blink4_hold", {31'b0, led[0]}, {31'b0, l0});
    tick();
    chk("blink4_toggle", {31'b0, led[0]}, {31'b0, ~l0});
    check_period4("blink4_period");

    run_cmd("set_blink1", cmd(1'b0, 4'd4, 27'd1), resp(1'b0, 1'b1, 4'd4, 26'd0));
    check_period4("blink_kept4");

    run_cmd("op9", cmd(1'b1, 4'd9, 27'h155), resp(1'b1, 1'b1, 4'd9, 26'd0));
    chk("op9_led", {23'b0, led[9:1]}, 32'h1A5);
    run_cmd("get_cnt", cmd(1'b0, 4'd5, 27'd0), resp(1'b0, 1'b0, 4'd5, 26'd7));

    // WAIT 10: ack on edge 13; a double req toggle mid-WAIT must be invisible.
    pp_out = cmd(1'b1, 4'd6, 27'd10);
    tick();
    tick(); tick(); tick();
    pp_out[31] = 1'b0;
    tick(); tick();
    pp_out[31] = 1'b1;
    repeat (6) tick();
    chk("wait_early", pp_in, last_resp);
    tick();
    chk("wait_resp", pp_in, resp(1'b1, 1'b0, 4'd6, 26'd10));
    last_resp = resp(1'b1, 1'b0, 4'd6, 26'd10);
    repeat (8) tick();
    chk("wait_no_extra", pp_in, last_resp);

    // Reset mid-WAIT: no response, and req bit 0 is not a new request afterwards.
    pp_out = cmd(1'b0, 4'd6, 27'd10);
    tick();
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("midwait_reset_pp_in", pp_in, 32'h0);
    chk("midwait_reset_led", {22'b0, led}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) tick();
    chk("post_reset_idle", pp_in, 32'h0);

    last_resp = '0;
    run_cmd("get_cnt_after_reset", cmd(1'b1, 4'd5, 27'd0), resp(1'b1, 1'b0, 4'd5, 26'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
